// File: rtl/vec_mag_pkg.sv
// Shared definitions for the Euclidean magnitude unit: FSM states and
// width/cycle helpers derived from the operand width.
package vec_mag_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        SQRT,
        DONE
    } state_t;

    function automatic int sq_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int mag_w(input int w);
        return w + 1;
    endfunction

    function automatic int rem_w(input int w);
        return w + 2;
    endfunction

    function automatic int sqr_cyc(input int w);
        return w;
    endfunction

    function automatic int sqrt_cyc(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential digit-by-digit integer square root: one root bit per cycle,
// MSB first; the load cycle already performs the first digit step.
module isqrt_seq #(
    parameter int NW = 17,
    parameter int RW = (NW + 1) / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [NW-1:0] n,
    output logic          done,
    output logic [RW-1:0] root,
    output logic [RW:0]   rem
);

    localparam int PW  = 2 * RW;
    localparam int RMW = RW + 1;
    localparam int CW  = $clog2(RW + 1);

    logic [PW-1:0]  n_q, n_src, n_nx;
    logic [RW-1:0]  root_q, root_src, root_nx;
    logic [RW:0]    rem_q, rem_src, rem_nx;
    logic [RW+2:0]  trial_rem, trial_sub;
    logic [CW-1:0]  cnt_q;
    logic           run_q, done_q;

    // A load starts from an empty root/remainder so the first step can share the datapath.
    always_comb begin
        n_src     = load ? PW'(n) : n_q;
        root_src  = load ? '0 : root_q;
        rem_src   = load ? '0 : rem_q;
        trial_rem = {rem_src, n_src[PW-1 -: 2]};
        trial_sub = {1'b0, root_src, 2'b01};
        n_nx      = n_src << 2;
        if (trial_rem >= trial_sub) begin
            rem_nx  = RMW'(trial_rem - trial_sub);
            root_nx = {root_src[RW-2:0], 1'b1};
        end else begin
            rem_nx  = RMW'(trial_rem);
            root_nx = {root_src[RW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q    <= '0;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                n_q    <= n_nx;
                root_q <= root_nx;
                rem_q  <= rem_nx;
                cnt_q  <= CW'(1);
                run_q  <= 1'b1;
            end else if (run_q) begin
                n_q    <= n_nx;
                root_q <= root_nx;
                rem_q  <= rem_nx;
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == CW'(RW - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign root = root_q;
    assign rem  = rem_q;

endmodule

// File: rtl/vec_mag_seq.sv
// Multi-cycle sqrt(x^2 + y^2): shift-add squaring of both operands in
// parallel, then a sequential integer square root, behind start/busy/done.
module vec_mag_seq
    import vec_mag_pkg::*;
#(
    parameter int W     = 8,
    parameter int ROUND = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          x,
    input  logic [W-1:0]          y,
    output logic                  busy,
    output logic                  done,
    output logic [mag_w(W)-1:0]   mag,
    output logic [sq_w(W)-1:0]    sumsq,
    output logic [rem_w(W)-1:0]   rem
);

    localparam int SQW  = sq_w(W);
    localparam int MAGW = mag_w(W);
    localparam int REMW = rem_w(W);
    localparam int CW   = $clog2(sqr_cyc(W) + 1);
    localparam logic [CW-1:0] SQR_LAST = CW'(sqr_cyc(W) - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    xb_q, yb_q;
    logic [2*W-1:0]  xa_q, ya_q, x2_q, y2_q;
    logic            ld_q;
    logic [SQW-1:0]  n_sum;
    logic [MAGW-1:0] root, mag_d;
    logic [REMW-1:0] root_rem;
    logic            sq_done;

    assign n_sum = SQW'(x2_q) + SQW'(y2_q);
    assign mag_d = (ROUND != 0 && root_rem > REMW'(root)) ? root + 1'b1 : root;

    isqrt_seq #(.NW(SQW)) u_isqrt (
        .clk  (clk),
        .rst  (rst),
        .load (ld_q),
        .n    (n_sum),
        .done (sq_done),
        .root (root),
        .rem  (root_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = SQR;
            SQR:  if (cnt_q == SQR_LAST) state_d = SQRT;
            SQRT: if (sq_done) state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the datapath is cleared on reset so an aborted operation leaves no stale results.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            xb_q  <= '0;
            yb_q  <= '0;
            xa_q  <= '0;
            ya_q  <= '0;
            x2_q  <= '0;
            y2_q  <= '0;
            ld_q  <= 1'b0;
            mag   <= '0;
            sumsq <= '0;
            rem   <= '0;
        end else begin
            ld_q <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    xb_q  <= x;
                    yb_q  <= y;
                    xa_q  <= (2*W)'(x);
                    ya_q  <= (2*W)'(y);
                    x2_q  <= '0;
                    y2_q  <= '0;
                    cnt_q <= '0;
                end
                SQR: begin
                    // One multiplier bit per cycle, LSB first, against a left-shifting multiplicand.
                    if (xb_q[0]) x2_q <= x2_q + xa_q;
                    if (yb_q[0]) y2_q <= y2_q + ya_q;
                    xa_q  <= xa_q << 1;
                    ya_q  <= ya_q << 1;
                    xb_q  <= xb_q >> 1;
                    yb_q  <= yb_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    ld_q  <= (cnt_q == SQR_LAST);
                end
                SQRT: if (sq_done) begin
                    mag   <= mag_d;
                    sumsq <= n_sum;
                    rem   <= root_rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mag_seq.sv
// Scoreboard bench for vec_mag_seq at W = 4, 8 and 12, both rounding modes:
// expectations are queued when an operation is launched and popped on done.
module tb_vec_mag_seq;

    typedef struct {
        int mag;
        int sumsq;
        int rem;
        int due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  start_g;
    logic [11:0] x_bus, y_bus;
    int          cyc;
    int          n_checks, n_pass;
    exp_t        sb[6][$];

    logic        busy_v[6], done_v[6];
    logic [12:0] mag_v[6];
    logic [24:0] sq_v[6];
    logic [13:0] rem_v[6];

    logic [4:0]  mag0, mag1;  logic [8:0]  sq0, sq1;  logic [5:0]  rem0, rem1;
    logic [8:0]  mag2, mag3;  logic [16:0] sq2, sq3;  logic [9:0]  rem2, rem3;
    logic [12:0] mag4, mag5;  logic [24:0] sq4, sq5;  logic [13:0] rem4, rem5;

    vec_mag_seq #(.W(4), .ROUND(0)) d0 (.clk(clk), .rst(rst), .start(start_g[0]), .x(x_bus[3:0]), .y(y_bus[3:0]),
        .busy(busy_v[0]), .done(done_v[0]), .mag(mag0), .sumsq(sq0), .rem(rem0));
    vec_mag_seq #(.W(4), .ROUND(1)) d1 (.clk(clk), .rst(rst), .start(start_g[0]), .x(x_bus[3:0]), .y(y_bus[3:0]),
        .busy(busy_v[1]), .done(done_v[1]), .mag(mag1), .sumsq(sq1), .rem(rem1));
    vec_mag_seq #(.W(8), .ROUND(0)) d2 (.clk(clk), .rst(rst), .start(start_g[1]), .x(x_bus[7:0]), .y(y_bus[7:0]),
        .busy(busy_v[2]), .done(done_v[2]), .mag(mag2), .sumsq(sq2), .rem(rem2));
    vec_mag_seq #(.W(8), .ROUND(1)) d3 (.clk(clk), .rst(rst), .start(start_g[1]), .x(x_bus[7:0]), .y(y_bus[7:0]),
        .busy(busy_v[3]), .done(done_v[3]), .mag(mag3), .sumsq(sq3), .rem(rem3));
    vec_mag_seq #(.W(12), .ROUND(0)) d4 (.clk(clk), .rst(rst), .start(start_g[2]), .x(x_bus), .y(y_bus),
        .busy(busy_v[4]), .done(done_v[4]), .mag(mag4), .sumsq(sq4), .rem(rem4));
    vec_mag_seq #(.W(12), .ROUND(1)) d5 (.clk(clk), .rst(rst), .start(start_g[2]), .x(x_bus), .y(y_bus),
        .busy(busy_v[5]), .done(done_v[5]), .mag(mag5), .sumsq(sq5), .rem(rem5));

    assign mag_v[0] = 13'(mag0); assign sq_v[0] = 25'(sq0); assign rem_v[0] = 14'(rem0);
    assign mag_v[1] = 13'(mag1); assign sq_v[1] = 25'(sq1); assign rem_v[1] = 14'(rem1);
    assign mag_v[2] = 13'(mag2); assign sq_v[2] = 25'(sq2); assign rem_v[2] = 14'(rem2);
    assign mag_v[3] = 13'(mag3); assign sq_v[3] = 25'(sq3); assign rem_v[3] = 14'(rem3);
    assign mag_v[4] = mag4;      assign sq_v[4] = sq4;      assign rem_v[4] = rem4;
    assign mag_v[5] = mag5;      assign sq_v[5] = sq5;      assign rem_v[5] = rem5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Golden model: exhaustive bitwise search for the floor root, independent of the digit method.
    function automatic exp_t model(input int d, input int xi, input int yi, input int due);
        exp_t   e;
        int     w;
        longint xm, ym, n, r, rm, t;
        w  = 4 + 4 * (d / 2);
        xm = longint'(xi) & ((longint'(1) << w) - 1);
        ym = longint'(yi) & ((longint'(1) << w) - 1);
        n  = xm * xm + ym * ym;
        r  = 0;
        for (int b = 14; b >= 0; b--) begin
            t = r + (longint'(1) << b);
            if (t * t <= n) r = t;
        end
        rm = n - r * r;
        e.mag   = int'(((d % 2) == 1 && rm > r) ? r + 1 : r);
        e.sumsq = int'(n);
        e.rem   = int'(rm);
        e.due   = due;
        return e;
    endfunction

    function automatic int lat(input int g);
        return 2 * (4 + 4 * g) + 2;
    endfunction

    task automatic push(input int g, input int xi, input int yi, input int due);
        sb[2*g].push_back(model(2*g, xi, yi, due));
        sb[2*g+1].push_back(model(2*g+1, xi, yi, due));
    endtask

    // Launch one operation on group g; returns at the negedge right after the accept edge.
    task automatic go(input int g, input int xi, input int yi);
        @(negedge clk);
        x_bus = 12'(xi);
        y_bus = 12'(yi);
        start_g[g] = 1'b1;
        push(g, xi, yi, cyc + 1 + lat(g));
        @(negedge clk);
        start_g[g] = 1'b0;
    endtask

    task automatic wait_group(input int g);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb[2*g].size() == 0 && sb[2*g+1].size() == 0) break;
        end
        check($sformatf("pending_g%0d", g), 32'(sb[2*g].size() + sb[2*g+1].size()), 32'd0);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (done_v[i] === 1'b1) begin
                if (sb[i].size() == 0) begin
                    check($sformatf("extra_done_d%0d", i), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb[i].pop_front();
                    check($sformatf("mag_d%0d", i),     32'(mag_v[i]), 32'(e.mag));
                    check($sformatf("sumsq_d%0d", i),   32'(sq_v[i]),  32'(e.sumsq));
                    check($sformatf("rem_d%0d", i),     32'(rem_v[i]), 32'(e.rem));
                    check($sformatf("latency_d%0d", i), 32'(cyc),      32'(e.due));
                end
            end
        end
    end

    initial begin
        int e;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start_g  = '0;
        x_bus    = '0;
        y_bus    = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rst_busy_d%0d", i),  32'(busy_v[i]), 32'd0);
            check($sformatf("rst_done_d%0d", i),  32'(done_v[i]), 32'd0);
            check($sformatf("rst_mag_d%0d", i),   32'(mag_v[i]),  32'd0);
            check($sformatf("rst_sumsq_d%0d", i), 32'(sq_v[i]),   32'd0);
            check($sformatf("rst_rem_d%0d", i),   32'(rem_v[i]),  32'd0);
        end
        rst = 1'b0;

        // 3-4-5 triangle, busy the cycle after accept, results held after done.
        go(1, 3, 4);
        check("busy_after_accept", 32'(busy_v[2]), 32'd1);
        wait_group(1);
        repeat (3) @(negedge clk);
        check("hold_mag",   32'(mag_v[2]), 32'd5);
        check("hold_sumsq", 32'(sq_v[2]),  32'd25);
        check("hold_busy",  32'(busy_v[2]), 32'd0);

        // Largest operands: mag 360 floor, 361 rounded.
        go(1, 255, 255);
        wait_group(1);
        check("max_mag_r0", 32'(mag_v[2]), 32'd360);
        check("max_mag_r1", 32'(mag_v[3]), 32'd361);
        check("max_rem",    32'(rem_v[2]), 32'd450);

        // Back-to-back with start held high: re-accept in the IDLE cycle after DONE.
        @(negedge clk);
        x_bus = 12'd0; y_bus = 12'd0;
        start_g[1] = 1'b1;
        e = cyc + 1;
        push(1, 0, 0, e + lat(1));
        wait_cyc(e + 19);
        x_bus = 12'd1; y_bus = 12'd1;
        push(1, 1, 1, e + 20 + lat(1));
        wait_cyc(e + 39);
        x_bus = 12'd5; y_bus = 12'd5;
        push(1, 5, 5, e + 40 + lat(1));
        wait_cyc(e + 40);
        start_g[1] = 1'b0;
        wait_group(1);
        check("b2b_last_mag", 32'(mag_v[2]), 32'd7);

        // Starts during SQR and SQRT are ignored.
        go(1, 10, 20);
        e = cyc;
        wait_cyc(e + 2);
        x_bus = 12'd200; y_bus = 12'd100; start_g[1] = 1'b1;
        @(negedge clk);
        start_g[1] = 1'b0;
        wait_cyc(e + 11);
        x_bus = 12'd7; y_bus = 12'd9; start_g[1] = 1'b1;
        @(negedge clk);
        start_g[1] = 1'b0;
        wait_group(1);
        repeat (25) @(negedge clk);

        // Reset in the middle of SQRT: outputs clear, no done follows.
        go(1, 100, 50);
        e = cyc;
        wait_cyc(e + 11);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy",  32'(busy_v[2]), 32'd0);
        check("midrst_done",  32'(done_v[2]), 32'd0);
        check("midrst_mag",   32'(mag_v[3]),  32'd0);
        check("midrst_sumsq", 32'(sq_v[2]),   32'd0);
        check("midrst_rem",   32'(rem_v[2]),  32'd0);
        sb[2].delete();
        sb[3].delete();
        rst = 1'b0;
        repeat (30) @(negedge clk);
        go(1, 6, 8);
        wait_group(1);

        // Boundaries and random operands for every width.
        for (int g = 0; g < 3; g++) begin
            go(g, 0, 0);
            wait_group(g);
            go(g, 'hfff, 'hfff);
            wait_group(g);
            go(g, 'hfff, 0);
            wait_group(g);
            for (int k = 0; k < 300; k++) begin
                go(g, int'($urandom), int'($urandom));
                wait_group(g);
            end
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
